// File: rtl/round_key_buffer_pkg.sv
// -----------------------------------------------------------------------------
// round_key_buffer_pkg
// Shared AES constants and types used by the round-key buffer and its helpers.
//   NR_DEFAULT  : default number of cipher rounds (AES-128 -> 10)
//   RCON_SEED   : round constant presented for round 1
//   RCON_POLY   : GF(2^8) reduction term applied by xtime when bit 7 overflows
//   KEY_W       : width of a cipher key / round key
//   rkb_state_t : expansion FSM state encoding
// -----------------------------------------------------------------------------
package round_key_buffer_pkg;

    localparam int         NR_DEFAULT = 10;
    localparam int         KEY_W      = 128;
    localparam logic [7:0] RCON_SEED  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } rkb_state_t;

endpackage

// File: rtl/round_key_buffer_rcon_next.sv
// -----------------------------------------------------------------------------
// rcon_next
// Combinational AES round-constant advance: GF(2^8) multiply by x (xtime).
//   rcon  : current round constant
//   xtime : constant for the following round (0x80 -> 0x1B, 0x1B -> 0x36)
// -----------------------------------------------------------------------------
module rcon_next
    import round_key_buffer_pkg::*;
(
    input  logic [7:0] rcon,
    output logic [7:0] xtime
);

    // Shift left; fold the bit that falls off back in through the field polynomial.
    always_comb begin
        xtime = {rcon[6:0], 1'b0} ^ (rcon[7] ? RCON_POLY : 8'h00);
    end

endmodule

// File: rtl/round_key_buffer.sv
// -----------------------------------------------------------------------------
// round_key_buffer
// Drives an external AES key-schedule stage one round at a time and stores the
// NR+1 round keys it returns, with a registered random-access read port.
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   start            : one-cycle request to expand cipher_key_i (ignored in GEN)
//   cipher_key_i     : cipher key, sampled in the start cycle
//   ks_en            : key-schedule stage enable, high for the whole expansion
//   ks_sel           : stage input-mux select (0 for round 1, 1 afterwards)
//   ks_rcon          : round constant for the round being generated
//   ks_key_i         : previous round key handed to the stage
//   ks_key_flag      : stage pulse, ks_key_o holds a finished round key
//   ks_key_o         : round key from the stage
//   rd_addr, rd_key  : read index 0..NR, data one cycle later (0 beyond NR)
//   key_valid        : per-entry written flags
//   busy, keys_ready : expansion in progress / all entries valid
// -----------------------------------------------------------------------------
module round_key_buffer
    import round_key_buffer_pkg::*;
#(
    parameter int NR = NR_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] cipher_key_i,
    output logic             ks_en,
    output logic             ks_sel,
    output logic [7:0]       ks_rcon,
    output logic [KEY_W-1:0] ks_key_i,
    input  logic             ks_key_flag,
    input  logic [KEY_W-1:0] ks_key_o,
    input  logic [3:0]       rd_addr,
    output logic [KEY_W-1:0] rd_key,
    output logic [NR:0]      key_valid,
    output logic             busy,
    output logic             keys_ready
);

    localparam logic [NR:0] VALID_FIRST = {{NR{1'b0}}, 1'b1};
    localparam logic [3:0]  LAST_ROUND  = 4'(NR);

    rkb_state_t       state;
    logic [3:0]       round;
    logic [7:0]       rcon_adv;
    logic             start_acc;
    logic             flag_acc;
    logic [KEY_W-1:0] keys [0:NR];

    rcon_next u_rcon_next (
        .rcon  (ks_rcon),
        .xtime (rcon_adv)
    );

    // start restarts from IDLE or DONE only; stage pulses count only while generating.
    always_comb begin
        start_acc = start && (state != ST_GEN);
        flag_acc  = ks_key_flag && (state == ST_GEN);
    end

    // Expansion FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            round      <= 4'd0;
            ks_en      <= 1'b0;
            ks_sel     <= 1'b0;
            ks_rcon    <= RCON_SEED;
            ks_key_i   <= '0;
            key_valid  <= '0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
        end else if (start_acc) begin
            // Restart clears every valid bit but entry 0; stale keys stay in storage.
            state      <= ST_GEN;
            round      <= 4'd1;
            ks_en      <= 1'b1;
            ks_sel     <= 1'b0;
            ks_rcon    <= RCON_SEED;
            ks_key_i   <= cipher_key_i;
            key_valid  <= VALID_FIRST;
            busy       <= 1'b1;
            keys_ready <= 1'b0;
        end else if (flag_acc) begin
            key_valid[round] <= 1'b1;
            ks_key_i         <= ks_key_o;
            if (round == LAST_ROUND) begin
                // Counter holds at NR; nothing further is requested from the stage.
                state      <= ST_DONE;
                ks_en      <= 1'b0;
                busy       <= 1'b0;
                keys_ready <= 1'b1;
            end else begin
                round   <= round + 4'd1;
                ks_rcon <= rcon_adv;
                ks_sel  <= 1'b1;
            end
        end
    end

    // Round-key storage and registered read port.
    // NOTE: the key array is reset because a read after reset must return zeros;
    // a storage array without that need would be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                keys[i] <= '0;
            end
            rd_key <= '0;
        end else begin
            if (start_acc) begin
                keys[0] <= cipher_key_i;
            end else if (flag_acc) begin
                keys[round] <= ks_key_o;
            end
            // NOTE: non-blocking assignment makes a same-cycle read of the entry
            // being written return its old contents.
            rd_key <= (int'(rd_addr) <= NR) ? keys[rd_addr] : '0;
        end
    end

endmodule
